// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Next search start: one past the last winner, wrapping at width.
  function automatic int unsigned pivot_inc(input int unsigned idx, input int unsigned width);
    return (idx + 1) % width;
  endfunction

endpackage

// File: rtl/masked_priority_encoder.sv
// Rotating priority encoder: finds the first set request starting at a pivot.
// DESCENDING=0 scans upward (lowest index >= pivot, else lowest index < pivot).
module masked_priority_encoder #(
  parameter int WIDTH = 4,
  parameter bit DESCENDING = 1'b0,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] pivot,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Visit candidates so that the preferred one in each window is written last.
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = DESCENDING ? i : (WIDTH - 1 - i);
      if (req[j]) begin
        if (DESCENDING ? (j <= int'(pivot)) : (j >= int'(pivot))) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(j);
        end
      end
    end
    valid = hi_found | lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Registered round-robin grant controller: owns the pivot, holds one-hot grants.
// Optional hold-timeout preemption is enabled with `define RR_HOLD_TIMEOUT_EN.
module rr_grant_sequencer
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_req,
  input  logic             i_release,
  output logic [WIDTH-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid,
  output logic             o_preempt
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || MAX_HOLD < 2) begin : g_bad_param
    $error("rr_grant_sequencer: WIDTH must be a power of two >= 2 and MAX_HOLD >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pivot_q, pivot_d;
  logic [WIDTH-1:0] enc_req;
  logic             enc_valid;
  logic [IDX_W-1:0] enc_idx;
  logic             hold_req;
  logic             timeout;
  logic             end_grant;
  logic             load;

  // The current holder is masked so a still-requesting holder cannot win twice in a row.
  assign enc_req  = i_req & ~grant_q;
  assign hold_req = i_req[idx_q];

  masked_priority_encoder #(
    .WIDTH      (WIDTH),
    .DESCENDING (1'b0)
  ) u_encoder (
    .req   (enc_req),
    .pivot (pivot_q),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;

  // Only preempt when someone else is actually waiting.
  assign timeout = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1)) && enc_valid;

  always_comb begin
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    if (load || state_d == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(MAX_HOLD - 1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A release or request drop on the same edge takes precedence over timeout.
    if (end_grant && timeout && !i_release && hold_req) begin
      preempt_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign o_preempt = preempt_q;
`else
  assign timeout   = 1'b0;
  assign o_preempt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    pivot_d   = pivot_q;
    end_grant = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        load = enc_valid;
      end
      GRANT: begin
        end_grant = i_release | ~hold_req | timeout;
        if (end_grant) begin
          if (enc_valid) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = GRANT;
      grant_d = WIDTH'(1) << enc_idx;
      idx_d   = enc_idx;
      pivot_d = IDX_W'(pivot_inc(32'(enc_idx), WIDTH));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      pivot_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      pivot_q <= pivot_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_idx   = idx_q;
  assign o_grant_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Self-checking bench for rr_grant_sequencer (WIDTH=4, MAX_HOLD=4).
// Timeout cases run only when RR_HOLD_TIMEOUT_EN is defined.
module tb_rr_grant_sequencer;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       preempt;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       preempt;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       i_release;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_grant_valid;
  logic       o_preempt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[18];

  rr_grant_sequencer #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (i_req),
    .i_release     (i_release),
    .o_grant       (o_grant),
    .o_grant_idx   (o_grant_idx),
    .o_grant_valid (o_grant_valid),
    .o_preempt     (o_preempt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    i_req     = v.req;
    i_release = v.rel;
    sb.push_back('{v.grant, v.idx, v.valid, v.preempt});
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " grant"},   32'(o_grant),       32'(e.grant));
      check({tag, " idx"},     32'(o_grant_idx),   32'(e.idx));
      check({tag, " valid"},   32'(o_grant_valid), 32'(e.valid));
      check({tag, " preempt"}, 32'(o_preempt),     32'(e.preempt));
    end
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst_n   = 1'b0;
    i_req     = '0;
    i_release = 1'b0;
    #2;
    i_rst_n   = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " grant"},   32'(o_grant),       32'd0);
    check({tag, " idx"},     32'(o_grant_idx),   32'd0);
    check({tag, " valid"},   32'(o_grant_valid), 32'd0);
    check({tag, " preempt"}, 32'(o_preempt),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            req      rel   grant    idx   vld   pre
    vecs[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // first win from pivot 0
    vecs[1]  = '{4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0}; // zero-gap handoff
    vecs[2]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0}; // new requests do not disturb
    vecs[3]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[8]  = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // all requests drop
    vecs[10] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // pivot wrapped to 0
    vecs[11] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // holder drops, handoff
    vecs[12] = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0}; // sole holder excluded
    vecs[13] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // regranted after gap
    vecs[14] = '{4'b0111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[15] = '{4'b0111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0}; // wrap below pivot 3
    vecs[16] = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

    i_rst_n   = 1'b0;
    i_req     = '0;
    i_release = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a grant, then restart at pivot 0.
    run_vec('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, "pre_rst");
    #2;
    i_rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    i_req = '0;
    #1;
    i_rst_n = 1'b1;
    run_vec('{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, "post_rst");

`ifdef RR_HOLD_TIMEOUT_EN
    // Competitor waits: grant moves after the 4th grant cycle with a preempt pulse.
    apply_reset();
    run_vec('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, "to_load");
    for (int i = 0; i < 3; i++) begin
      run_vec('{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, $sformatf("to_hold%0d", i));
    end
    run_vec('{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1}, "to_preempt");
    run_vec('{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}, "to_pulse_end");

    // No competitor: holder keeps the grant; a late competitor preempts at once.
    apply_reset();
    run_vec('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, "sat_load");
    for (int i = 0; i < 6; i++) begin
      run_vec('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, $sformatf("sat_hold%0d", i));
    end
    run_vec('{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1}, "sat_preempt");

    // Release coinciding with timeout counts as a plain release.
    apply_reset();
    run_vec('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, "rel_load");
    for (int i = 0; i < 3; i++) begin
      run_vec('{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, $sformatf("rel_hold%0d", i));
    end
    run_vec('{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0}, "rel_and_timeout");
`else
    // Without the timeout feature a waiting competitor never preempts.
    apply_reset();
    run_vec('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, "nto_load");
    for (int i = 0; i < 6; i++) begin
      run_vec('{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}, $sformatf("nto_hold%0d", i));
    end
    run_vec('{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0}, "nto_release");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_sequencer.md
# rr_grant_sequencer

Registered round-robin grant controller that owns the rotating pivot and drives the combinational masked priority encoder. It is the stateful stage directly downstream of the encoder: it consumes the encoder's winning index, registers it as a one-hot grant, holds the grant until the grantee releases it, and advances the pivot so the next search starts just past the last winner. It forms the sequential core of the round-robin arbiter.

## Interface
Parameters:
- WIDTH, 4, number of requesters; ≥2, power of two
- MAX_HOLD, 16, max grant cycles before preemption (only used with the timeout feature); ≥2

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_req  input  WIDTH  level request per requester
- i_release  input  1  current grantee finished; sampled only while o_grant_valid
- o_grant  output  WIDTH  registered one-hot grant, zero when idle
- o_grant_idx  output  $clog2(WIDTH)  index of o_grant, 0 when idle
- o_grant_valid  output  1  grant active
- o_preempt  output  1  one-cycle pulse when a grant ended by timeout (tied 0 without macro)

## Operation
- Reset (async assert, sync-safe deassert): state IDLE, pivot 0, o_grant 0, o_grant_idx 0, o_grant_valid 0, hold counter 0, o_preempt 0.
- Encoder input: i_req & ~o_grant, pivot register; ascending scan (LSB=0): lowest index ≥ pivot, else lowest index < pivot.
- States: IDLE, GRANT.
- IDLE: if encoder valid at edge, load winner w: o_grant = 1<<w, valid 1, pivot = (w+1) mod WIDTH, counter 0, go GRANT. Else stay.
- GRANT end condition at an edge: i_release | ~i_req[o_grant_idx] | timeout.
- On end: if encoder valid, load new winner w (same updates), stay GRANT, zero-gap handoff; else clear grant, go IDLE.
- Grant not ending: o_grant/idx/pivot unchanged; counter increments.
- Holder still requesting at end is excluded from that edge's search; re-eligible from next cycle.
- Requests arriving mid-grant never alter the current grant.
- Pivot wrap: WIDTH-1 winner gives pivot 0 (natural width truncation).

## Timing
- Request to grant: 1 cycle (request high before edge t, o_grant valid after edge t).
- Release to next grant: 0 idle cycles when another request is pending; release and new grant are the same edge.
- Release with no other request: o_grant_valid low after that edge; re-request → grant one edge later.
- Simultaneous i_release and timeout: treated as a release, o_preempt stays 0.
- Reset mid-grant: all outputs drop immediately, asynchronously.

## Configuration
- RR_HOLD_TIMEOUT_EN defined: counter width $clog2(MAX_HOLD+1). Timeout is true when counter == MAX_HOLD-1 and the encoder is valid, meaning another requester is waiting. Timeout ends the grant and pulses o_preempt for one cycle after that edge. With no other requester, the counter saturates and the holder keeps the grant.
- Undefined: no counter, timeout always false, o_preempt tied 0; grant lasts until release or request drop.

## Structure
- Shared package rr_arbiter_pkg holds: state enum (IDLE, GRANT) and a pivot-increment function (idx+1 mod WIDTH).
- One sub-module: masked_priority_encoder #(WIDTH, 0), instanced once; all state lives in this block.

## Test plan
- WIDTH=4, i_req=4'b1010 from reset: grant 4'b0010 idx 1 after first edge; pivot 2; on i_release, grant 4'b1000 on the same edge.
- i_req=4'b1111, release every cycle: grants 0,1,2,3,0 on consecutive cycles, o_grant_valid never drops.
- Grant idx 3, all requests drop: o_grant 0, valid 0 next edge; i_req=4'b0001: grant idx 0 one edge later (pivot wrap).
- Sole requester 2 releases while holding i_req[2]: one IDLE cycle, then regranted idx 2.
- RR_HOLD_TIMEOUT_EN, MAX_HOLD=4: idx 0 holds, requester 2 asserts. After the 4th grant cycle, grant moves to idx 2 with o_preempt=1 for one cycle. Without a competitor, the holder keeps the grant past 4 cycles.
- Assert i_rst_n=0 mid-grant: outputs zero without a clock edge; after deassert, arbitration restarts at pivot 0.
